fc_layer: RTL and testbench
===========================

Name: fc_layer

Overview:
- Generic fully-connected layer engine: one sequential MAC pass over a full input vector, with NUM_NEURONS neurons in parallel and an optional ReLU.
- Replaces per-layer hard-coded instances. Inputs, neurons, widths and fixed-point format are all parameters.
- Weights and biases come from external per-layer ROMs through a shared address port, so one RTL body serves every layer.
- Sits between layer N-1's output register and layer N+1's input, with valid/ready handshakes on both sides.

Parameters:
- LAYER_NUM, 0, layer index; informational only, passed to the weight ROM wrapper.
- NUM_INPUTS, 784, input vector length N (>=1).
- NUM_NEURONS, 16, neuron count M (>=1).
- DATA_WIDTH, 16, signed width W of inputs, weights, biases and outputs.
- FRAC_WIDTH, 10, fractional bits F shared by all fixed-point values.
- ADDR_WIDTH, $clog2(NUM_INPUTS), weight address width; minimum 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- in_vec  in  W*N  input vector; element k at [k*W +: W].
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector.
- w_addr  out  ADDR_WIDTH  weight ROM address (input index k).
- w_data  in  W*M  weights for index k, returned 1 cycle after w_addr; neuron j at [j*W +: W].
- bias  in  W*M  per-neuron biases; static while busy.
- layer_out  out  W*M  results; neuron j at [j*W +: W].
- out_valid  out  1  layer_out is valid.
- out_ready  in  1  downstream accepts layer_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: IDLE; in_ready=1; out_valid=0; busy=0; layer_out=0; w_addr=0; accumulators=0. Reset in any state aborts the pass. No partial result is ever presented.
- FSM states: IDLE, MAC, FLUSH, FINAL, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready (cycle T): capture in_vec into an internal register, clear accumulators, set index=0, go to MAC.
- MAC: w_addr=index. Index increments each cycle from 0 to N-1, and on N-1 the FSM moves to FLUSH. Each cycle, acc[j] += x[k-1]*w_data[j] for the previous cycle's address, once valid data is returned.
- FLUSH: one cycle; accumulates the last product (k=N-1).
- FINAL: one cycle. Per neuron, r = (acc + (sext(bias)<<F)) >>> F, arithmetic shift (floor). Then saturate r to [-2^(W-1), 2^(W-1)-1], apply the optional activation, register into layer_out, and go to HOLD.
- HOLD: out_valid=1, layer_out stable. On out_ready: out_valid drops the next cycle and the FSM returns to IDLE. Holds indefinitely without out_ready.
- Latency: out_valid first high at T+N+3, where T is the accept cycle. in_ready=0 from T+1 until the cycle after the output handshake, so the minimum vector period is N+4 cycles.
- Arithmetic widths:
  - product: 2W bits with 2F fractional bits.
  - ACC_W = 2W + clog2(N) + 1, so the accumulator never overflows.
  - Saturation applies only at the output.
- N=1: MAC lasts exactly 1 cycle. Index wrap is impossible because index stops at N-1.
- in_valid while not IDLE is ignored (no capture). in_vec may change freely after the accept cycle.

Optional Feature:
- Macro: FC_LAYER_RELU_EN.
- Defined: ReLU after saturation; negative results become 0.
- Undefined: linear; the saturated value is passed unchanged.
- Latency is identical in both builds.

Test Plan:
- Basic (W=16, F=10, N=4, M=2):
  - Stimulus: in_vec all 1024 (1.0); w_data neuron0=512, neuron1=-256; bias 256 and 0; out_ready=1.
  - Response: out_valid at T+7; layer_out = {2304, -1024} with ReLU undefined, {2304, 0} with FC_LAYER_RELU_EN.
- Saturation: inputs and weights all 31744 (31.0), bias 0, N=4 → every neuron 32767. With inputs negated → -32768 (linear build).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - layer_out and out_valid stay stable; in_ready=0; a new in_valid is ignored.
  - Raise out_ready: out_valid=0 and in_ready=1 the next cycle.
- Reset mid-MAC: assert reset at T+2 for 1 cycle.
  - Next cycle: IDLE, in_ready=1, out_valid=0, layer_out=0.
  - A fresh vector then produces the correct result from the basic test.
- Back-to-back: 3 vectors (x=1.0, 2.0, -1.0; weights 512; bias 0; N=4), in_valid held high, out_ready=1.
  - Outputs in order: 2048, 4096, -2048.
  - Accept cycles spaced exactly N+4 = 8 cycles apart.
- Edge N=1, M=1: x=1024, w=-1 (LSB), bias 0 → -1 via floor; w_addr stays 0 throughout.

Source files
------------

// File: rtl/fc_layer.sv
// Fully-connected layer engine: sequential MAC over the input vector, all neurons in parallel.
// Define FC_LAYER_RELU_EN to clamp negative outputs to zero after saturation.
module fc_layer #(
  parameter int LAYER_NUM   = 0,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 10,
  parameter int ADDR_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]  in_vec,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [ADDR_WIDTH-1:0]             w_addr,
  input  logic [DATA_WIDTH*NUM_NEURONS-1:0] w_data,
  input  logic [DATA_WIDTH*NUM_NEURONS-1:0] bias,
  output logic [DATA_WIDTH*NUM_NEURONS-1:0] layer_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);
  localparam int W     = DATA_WIDTH;
  localparam int N     = NUM_INPUTS;
  localparam int M     = NUM_NEURONS;
  localparam int ACC_W = 2*W + $clog2(N) + 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N-1);
  localparam logic signed [SUM_W-1:0] SMAX = SUM_W'({1'b0, {(W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SMIN = -SMAX - 1;

  typedef enum logic [2:0] {IDLE, MAC, FLUSH, FINAL, HOLD} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   pidx;
  logic signed [W-1:0]     x    [N];
  logic signed [ACC_W-1:0] acc  [M];
  logic signed [2*W-1:0]   prod [M];
  logic signed [SUM_W-1:0] sum  [M];
  logic signed [SUM_W-1:0] sh   [M];
  logic signed [W-1:0]     res  [M];
  logic                    acc_en;
  logic                    accept;

  assign w_addr = idx;
  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && in_valid && in_ready;
  // ROM data lags the address by a cycle, so the first MAC cycle has nothing to add
  assign acc_en = (state == FLUSH) || ((state == MAC) && (idx != '0));

  always_comb begin
    for (int j = 0; j < M; j++) begin
      prod[j] = x[pidx] * $signed(w_data[j*W +: W]);
      sum[j]  = SUM_W'(acc[j])
              + (SUM_W'($signed(bias[j*W +: W])) <<< FRAC_WIDTH);
      sh[j]   = sum[j] >>> FRAC_WIDTH;
      if (sh[j] > SMAX) begin
        res[j] = {1'b0, {(W-1){1'b1}}};
      end else if (sh[j] < SMIN) begin
        res[j] = {1'b1, {(W-1){1'b0}}};
      end else begin
        res[j] = sh[j][W-1:0];
      end
`ifdef FC_LAYER_RELU_EN
      if (res[j][W-1]) res[j] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N; k++) x[k] <= in_vec[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      layer_out <= '0;
      idx       <= '0;
      pidx      <= '0;
      for (int j = 0; j < M; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int j = 0; j < M; j++) acc[j] <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          pidx <= idx;
          if (idx == LAST) begin
            idx   <= '0;
            state <= FLUSH;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FLUSH: state <= FINAL;
        FINAL: begin
          for (int j = 0; j < M; j++) layer_out[j*W +: W] <= res[j];
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (acc_en) begin
        for (int j = 0; j < M; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
      end
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: N=4/M=2 instance with scoreboard plus an N=1/M=1 edge instance.
// Expected values follow the ReLU build when FC_LAYER_RELU_EN is defined.
module tb_fc_layer;
  logic clk;
  logic reset;

  logic [63:0] in_vec_a;
  logic        in_valid_a;
  logic        in_ready_a;
  logic [1:0]  w_addr_a;
  logic [31:0] w_data_a;
  logic [31:0] bias_a;
  logic [31:0] layer_out_a;
  logic        out_valid_a;
  logic        out_ready_a;
  logic        busy_a;

  logic [15:0] in_vec_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [0:0]  w_addr_b;
  logic [15:0] w_data_b;
  logic [15:0] bias_b;
  logic [15:0] layer_out_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic        busy_b;

  logic signed [15:0] xs [4];
  logic signed [15:0] wr [4][2];
  logic signed [15:0] bs [2];
  logic signed [15:0] wb;

  logic [31:0] sb_a [$];
  int          lat_q [$];
  int          acc_hist [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        ov_prev = 1'b0;

  fc_layer #(
    .LAYER_NUM(1), .NUM_INPUTS(4), .NUM_NEURONS(2),
    .DATA_WIDTH(16), .FRAC_WIDTH(10)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_vec(in_vec_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .bias(bias_a),
    .layer_out(layer_out_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .busy(busy_a)
  );

  fc_layer #(
    .LAYER_NUM(2), .NUM_INPUTS(1), .NUM_NEURONS(1),
    .DATA_WIDTH(16), .FRAC_WIDTH(10)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_vec(in_vec_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .bias(bias_b),
    .layer_out(layer_out_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight ROMs with one cycle of read latency
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) w_data_a[j*16 +: 16] <= wr[w_addr_a][j];
    w_data_b <= wb;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic miss(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] model_a();
    logic [31:0] r;
    longint s;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += longint'(xs[k]) * longint'(wr[k][j]);
      s += longint'(bs[j]) * 1024;
      s = s >>> 10;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`ifdef FC_LAYER_RELU_EN
      if (s < 0) s = 0;
`endif
      r[j*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic load_a();
    for (int k = 0; k < 4; k++) in_vec_a[k*16 +: 16] = xs[k];
    for (int j = 0; j < 2; j++) bias_a[j*16 +: 16] = bs[j];
  endtask

  // Per-cycle monitor for instance A, then advance one clock
  task automatic cyc_a(output bit acc);
    logic [31:0] e;
    int t;
    acc = 1'b0;
    if (out_valid_a && !ov_prev) begin
      if (lat_q.size() == 0) miss("lat_no_accept");
      else begin
        t = lat_q.pop_front();
        chk("latency", 64'(cyc - t), 64'(7));
      end
    end
    if (out_valid_a && out_ready_a) begin
      if (sb_a.size() == 0) miss("sb_empty");
      else begin
        e = sb_a.pop_front();
        chk("layer_out", 64'(layer_out_a), 64'(e));
      end
    end
    if (in_valid_a && in_ready_a) begin
      lat_q.push_back(cyc);
      acc_hist.push_back(cyc);
      acc = 1'b1;
    end
    ov_prev = out_valid_a;
    tick();
  endtask

  task automatic drain_a(input string tag);
    bit a;
    int n;
    n = 0;
    while (sb_a.size() != 0 && n < 60) begin
      cyc_a(a);
      n++;
    end
    if (sb_a.size() != 0) begin
      miss(tag);
      sb_a.delete();
    end
  endtask

  task automatic run_a(input string tag, input logic [31:0] exp);
    bit a;
    load_a();
    in_valid_a = 1'b1;
    sb_a.push_back(exp);
    cyc_a(a);
    chk({tag, "_accept"}, 64'(a), 64'(1));
    in_valid_a = 1'b0;
    chk({tag, "_in_ready_low"}, 64'(in_ready_a), 64'(0));
    chk({tag, "_busy"}, 64'(busy_a), 64'(1));
    drain_a({tag, "_drain"});
  endtask

  initial begin
    bit a;
    int n;
    logic [31:0] hold_val;
    logic [31:0] basic_exp;
    logic [15:0] b_exp;

    reset = 1'b1;
    in_vec_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1; bias_a = '0;
    in_vec_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1; bias_b = '0;
    wb = '0;
    for (int k = 0; k < 4; k++) begin
      xs[k] = '0;
      for (int j = 0; j < 2; j++) wr[k][j] = '0;
    end
    bs[0] = '0; bs[1] = '0;
    tick(); tick();

    chk("rst_in_ready", 64'(in_ready_a), 64'(1));
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_layer_out", 64'(layer_out_a), 64'(0));
    chk("rst_w_addr", 64'(w_addr_a), 64'(0));
    chk("rst_b_busy", 64'(busy_b), 64'(0));
    reset = 1'b0;
    tick();

    // Basic: x=1.0, w0=0.5, w1=-0.25, bias 0.25 and 0
`ifdef FC_LAYER_RELU_EN
    basic_exp = {16'd0, 16'd2304};
`else
    basic_exp = {16'hFC00, 16'd2304};
`endif
    for (int k = 0; k < 4; k++) begin
      xs[k] = 16'sd1024; wr[k][0] = 16'sd512; wr[k][1] = -16'sd256;
    end
    bs[0] = 16'sd256; bs[1] = 16'sd0;
    load_a();
    in_valid_a = 1'b1;
    sb_a.push_back(basic_exp);
    cyc_a(a);
    in_valid_a = 1'b0;
    chk("basic_accept", 64'(a), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("basic_w_addr", 64'(w_addr_a), 64'(k));
      cyc_a(a);
    end
    drain_a("basic_drain");
    chk("basic_model", 64'(model_a()), 64'(basic_exp));

    // Saturation, positive then negative
    for (int k = 0; k < 4; k++) begin
      xs[k] = 16'sd31744; wr[k][0] = 16'sd31744; wr[k][1] = 16'sd31744;
    end
    bs[0] = '0; bs[1] = '0;
    run_a("sat_pos", {16'h7FFF, 16'h7FFF});
    for (int k = 0; k < 4; k++) xs[k] = -16'sd31744;
`ifdef FC_LAYER_RELU_EN
    run_a("sat_neg", 32'h0000_0000);
`else
    run_a("sat_neg", {16'h8000, 16'h8000});
`endif

    // Backpressure
    for (int k = 0; k < 4; k++) begin
      xs[k] = 16'sd1024; wr[k][0] = 16'sd512; wr[k][1] = -16'sd256;
    end
    bs[0] = 16'sd256; bs[1] = 16'sd0;
    load_a();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    sb_a.push_back(basic_exp);
    cyc_a(a);
    in_valid_a = 1'b0;
    n = 0;
    while (!out_valid_a && n < 40) begin
      cyc_a(a);
      n++;
    end
    if (!out_valid_a) miss("bp_wait_valid");
    hold_val = layer_out_a;
    for (int k = 0; k < 4; k++) in_vec_a[k*16 +: 16] = 16'sd77;
    in_valid_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid_a), 64'(1));
      chk("bp_stable", 64'(layer_out_a), 64'(hold_val));
      chk("bp_in_ready", 64'(in_ready_a), 64'(0));
      cyc_a(a);
      chk("bp_no_accept", 64'(a), 64'(0));
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    cyc_a(a);
    chk("bp_release_valid", 64'(out_valid_a), 64'(0));
    chk("bp_release_ready", 64'(in_ready_a), 64'(1));
    chk("bp_sb_empty", 64'(sb_a.size()), 64'(0));

    // Reset two cycles after accept aborts the pass
    load_a();
    in_valid_a = 1'b1;
    cyc_a(a);
    in_valid_a = 1'b0;
    cyc_a(a);
    reset = 1'b1;
    cyc_a(a);
    reset = 1'b0;
    lat_q.delete();
    ov_prev = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready_a), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("mid_rst_layer_out", 64'(layer_out_a), 64'(0));
    chk("mid_rst_busy", 64'(busy_a), 64'(0));
    run_a("after_rst", basic_exp);

    // Back-to-back: x = 1.0, 2.0, -1.0 with weight 0.5
    for (int k = 0; k < 4; k++) begin
      wr[k][0] = 16'sd512; wr[k][1] = 16'sd512;
    end
    bs[0] = '0; bs[1] = '0;
    acc_hist.delete();
    for (int k = 0; k < 4; k++) xs[k] = 16'sd1024;
    load_a();
    sb_a.push_back({16'd2048, 16'd2048});
    in_valid_a = 1'b1;
    n = 0;
    while ((acc_hist.size() < 3 || sb_a.size() != 0) && n < 80) begin
      cyc_a(a);
      n++;
      if (a && acc_hist.size() == 1) begin
        for (int k = 0; k < 4; k++) xs[k] = 16'sd2048;
        load_a();
        sb_a.push_back({16'd4096, 16'd4096});
      end else if (a && acc_hist.size() == 2) begin
        for (int k = 0; k < 4; k++) xs[k] = -16'sd1024;
        load_a();
`ifdef FC_LAYER_RELU_EN
        sb_a.push_back(32'h0);
`else
        sb_a.push_back({16'hF800, 16'hF800});
`endif
      end else if (a) begin
        in_valid_a = 1'b0;
      end
    end
    in_valid_a = 1'b0;
    if (acc_hist.size() != 3 || sb_a.size() != 0) begin
      miss("b2b_complete");
      sb_a.delete();
    end else begin
      chk("b2b_gap1", 64'(acc_hist[1] - acc_hist[0]), 64'(8));
      chk("b2b_gap2", 64'(acc_hist[2] - acc_hist[1]), 64'(8));
    end

    // Random vectors with per-index weights against the model
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 4; k++) begin
        xs[k] = 16'($urandom_range(0, 8191)) - 16'sd4096;
        for (int j = 0; j < 2; j++)
          wr[k][j] = 16'($urandom_range(0, 4095)) - 16'sd2048;
      end
      for (int j = 0; j < 2; j++) bs[j] = 16'($urandom_range(0, 2047)) - 16'sd1024;
      run_a("rand", model_a());
    end

    // Edge N=1, M=1: 1.0 * -1 LSB floors to -1
`ifdef FC_LAYER_RELU_EN
    b_exp = 16'h0000;
`else
    b_exp = 16'hFFFF;
`endif
    in_vec_b = 16'sd1024;
    wb = -16'sd1;
    bias_b = '0;
    in_valid_b = 1'b1;
    chk("b_in_ready", 64'(in_ready_b), 64'(1));
    n = cyc;
    tick();
    in_valid_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("b_w_addr", 64'(w_addr_b), 64'(0));
      if (out_valid_b) break;
      tick();
    end
    if (!out_valid_b) miss("b_wait_valid");
    else begin
      chk("b_latency", 64'(cyc - n), 64'(4));
      chk("b_layer_out", 64'(layer_out_b), 64'(b_exp));
    end
    tick();
    chk("b_idle", 64'(in_ready_b), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
